// File: rtl/reg_bank4x16_pkg.sv
// -----------------------------------------------------------------------------
// reg_bank4x16_pkg
// Shared constants for the Level-01 register bank: datapath word width,
// symbolic register indices, the default reset/clear value and a one-hot
// write-address decoder.
// No ports (package).
// -----------------------------------------------------------------------------
package reg_bank4x16_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [1:0]        reg_idx_t;

    localparam reg_idx_t REG_R0 = 2'd0;
    localparam reg_idx_t REG_R1 = 2'd1;
    localparam reg_idx_t REG_R2 = 2'd2;
    localparam reg_idx_t REG_R3 = 2'd3;

    localparam word_t DEFAULT_RESET_VAL = 16'h0000;

    // One-hot decode of a register index into the four storage slots.
    function automatic logic [3:0] addr_decode(input reg_idx_t idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/reg_bank4x16_mux.sv
// -----------------------------------------------------------------------------
// reg_bank4x16_mux
// Datapath selector primitives used by the register bank read ports.
//   mux4way16 : in0..in3 (16b), sel (2b) -> y (16b), y = in[sel]
//   mux16     : a, b (16b), sel (1b)      -> y (16b), y = sel ? b : a
// -----------------------------------------------------------------------------
module mux4way16
    import reg_bank4x16_pkg::*;
(
    input  logic [WORD_W-1:0] in0,
    input  logic [WORD_W-1:0] in1,
    input  logic [WORD_W-1:0] in2,
    input  logic [WORD_W-1:0] in3,
    input  logic [1:0]        sel,
    output logic [WORD_W-1:0] y
);

    always_comb begin
        case (sel)
            REG_R0:  y = in0;
            REG_R1:  y = in1;
            REG_R2:  y = in2;
            default: y = in3;
        endcase
    end

endmodule

module mux16
    import reg_bank4x16_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              sel,
    output logic [WORD_W-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/reg_bank4x16.sv
// -----------------------------------------------------------------------------
// reg_bank4x16
// Four-entry, 16-bit register bank with two combinational select-read ports,
// one write port, synchronous clear, per-register dirty flags and a
// modulo-256 write counter.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data  write strobe, destination index, write data
//   clr                    synchronous clear (wins over a same-cycle write)
//   rd_sel_a/rd_data_a     read port A (0-cycle latency, optional bypass)
//   rd_sel_b/rd_data_b     read port B (0-cycle latency, optional bypass)
//   q0..q3                 stored register contents, never bypassed
//   dirty                  dirty[i] set once register i written since reset/clr
//   wr_cnt                 count of accepted writes, wraps at 256
// Parameters:
//   RESET_VAL  value loaded on reset and on clr
//   BYPASS     1: a read port selecting the register being written returns
//              wr_data in the same cycle
// -----------------------------------------------------------------------------
module reg_bank4x16
    import reg_bank4x16_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_VAL = DEFAULT_RESET_VAL,
    parameter bit                BYPASS    = 1'b1
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [1:0]        wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              clr,
    input  logic [1:0]        rd_sel_a,
    output logic [WORD_W-1:0] rd_data_a,
    input  logic [1:0]        rd_sel_b,
    output logic [WORD_W-1:0] rd_data_b,
    output logic [WORD_W-1:0] q0,
    output logic [WORD_W-1:0] q1,
    output logic [WORD_W-1:0] q2,
    output logic [WORD_W-1:0] q3,
    output logic [3:0]        dirty,
    output logic [7:0]        wr_cnt
);

    word_t      regs_q [4];
    word_t      regs_d [4];
    logic [3:0] dirty_q, dirty_d;
    logic [7:0] wr_cnt_q, wr_cnt_d;
    logic [3:0] wr_sel;

    word_t      sel_a, sel_b;
    logic       wr_live;
    logic       byp_a, byp_b;

    assign wr_sel = addr_decode(wr_addr);

    // Next-state: clear beats write, and a dropped write is not counted.
    always_comb begin
        regs_d   = regs_q;
        dirty_d  = dirty_q;
        wr_cnt_d = wr_cnt_q;
        if (clr) begin
            for (int i = 0; i < 4; i++) begin
                regs_d[i] = RESET_VAL;
            end
            dirty_d  = 4'b0000;
            wr_cnt_d = 8'h00;
        end else if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_sel[i]) begin
                    regs_d[i] = wr_data;
                end
            end
            dirty_d  = dirty_q | wr_sel;
            wr_cnt_d = wr_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= RESET_VAL;
            end
            dirty_q  <= 4'b0000;
            wr_cnt_q <= 8'h00;
        end else begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= regs_d[i];
            end
            dirty_q  <= dirty_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign q0     = regs_q[0];
    assign q1     = regs_q[1];
    assign q2     = regs_q[2];
    assign q3     = regs_q[3];
    assign dirty  = dirty_q;
    assign wr_cnt = wr_cnt_q;

    // A write only forwards when it will actually land; gating with rst_n
    // keeps the read ports at RESET_VAL while reset is held.
    assign wr_live = BYPASS && rst_n && wr_en && !clr;
    assign byp_a   = wr_live && (rd_sel_a == wr_addr);
    assign byp_b   = wr_live && (rd_sel_b == wr_addr);

    mux4way16 u_sel_a (
        .in0 (regs_q[0]),
        .in1 (regs_q[1]),
        .in2 (regs_q[2]),
        .in3 (regs_q[3]),
        .sel (rd_sel_a),
        .y   (sel_a)
    );

    mux4way16 u_sel_b (
        .in0 (regs_q[0]),
        .in1 (regs_q[1]),
        .in2 (regs_q[2]),
        .in3 (regs_q[3]),
        .sel (rd_sel_b),
        .y   (sel_b)
    );

    mux16 u_byp_a (
        .a   (sel_a),
        .b   (wr_data),
        .sel (byp_a),
        .y   (rd_data_a)
    );

    mux16 u_byp_b (
        .a   (sel_b),
        .b   (wr_data),
        .sel (byp_b),
        .y   (rd_data_b)
    );

endmodule

// File: tb/tb_reg_bank4x16.sv
// -----------------------------------------------------------------------------
// tb_reg_bank4x16
// Scoreboard bench for reg_bank4x16. Two instances share all inputs: one with
// forwarding enabled and one without. Each stimulus step pushes the expected
// outputs into a queue; an independent monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_reg_bank4x16;

    localparam logic [15:0] RV = 16'h0000;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [15:0] wr_data;
    logic        clr;
    logic [1:0]  rd_sel_a;
    logic [1:0]  rd_sel_b;

    logic [15:0] rd_data_a, rd_data_b, q0, q1, q2, q3;
    logic [3:0]  dirty;
    logic [7:0]  wr_cnt;

    logic [15:0] nb_rd_a, nb_rd_b, nb_q0, nb_q1, nb_q2, nb_q3;
    logic [3:0]  nb_dirty;
    logic [7:0]  nb_wr_cnt;

    typedef struct {
        string       tag;
        logic [15:0] rd_a;
        logic [15:0] rd_b;
        logic [15:0] rd_a_nb;
        logic [15:0] rd_b_nb;
        logic [15:0] q0, q1, q2, q3;
        logic [3:0]  dirty;
        logic [7:0]  cnt;
    } exp_t;

    exp_t exp_q[$];

    logic [15:0] m_reg [4];
    logic [3:0]  m_dirty;
    logic [7:0]  m_cnt;

    int checks = 0;
    int errors = 0;

    reg_bank4x16 #(.RESET_VAL(RV), .BYPASS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .clr(clr), .rd_sel_a(rd_sel_a), .rd_data_a(rd_data_a),
        .rd_sel_b(rd_sel_b), .rd_data_b(rd_data_b), .q0(q0), .q1(q1), .q2(q2),
        .q3(q3), .dirty(dirty), .wr_cnt(wr_cnt)
    );

    reg_bank4x16 #(.RESET_VAL(RV), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .clr(clr), .rd_sel_a(rd_sel_a), .rd_data_a(nb_rd_a),
        .rd_sel_b(rd_sel_b), .rd_data_b(nb_rd_b), .q0(nb_q0), .q1(nb_q1), .q2(nb_q2),
        .q3(nb_q3), .dirty(nb_dirty), .wr_cnt(nb_wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model reset, applied whenever rst_n is pulled low.
    task automatic modelReset();
        for (int i = 0; i < 4; i++) m_reg[i] = RV;
        m_dirty = 4'b0000;
        m_cnt   = 8'h00;
    endtask

    // Build the expected output snapshot from the model and current inputs.
    function automatic exp_t expectNow(input string tag);
        exp_t e;
        logic live;
        live      = rst_n && wr_en && !clr;
        e.tag     = tag;
        e.rd_a    = (live && rd_sel_a == wr_addr) ? wr_data : m_reg[rd_sel_a];
        e.rd_b    = (live && rd_sel_b == wr_addr) ? wr_data : m_reg[rd_sel_b];
        e.rd_a_nb = m_reg[rd_sel_a];
        e.rd_b_nb = m_reg[rd_sel_b];
        e.q0      = m_reg[0];
        e.q1      = m_reg[1];
        e.q2      = m_reg[2];
        e.q3      = m_reg[3];
        e.dirty   = m_dirty;
        e.cnt     = m_cnt;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act,
                               input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Drive one cycle: inputs at the falling edge, snapshot pushed before the
    // rising edge, model advanced by what the rising edge should do.
    task automatic applyStimulus(input logic we, input logic [1:0] wa,
                                 input logic [15:0] wd, input logic c,
                                 input logic [1:0] sa, input logic [1:0] sb,
                                 input string tag);
        @(negedge clk);
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        clr      = c;
        rd_sel_a = sa;
        rd_sel_b = sb;
        #1;
        exp_q.push_back(expectNow(tag));
        #2;
        @(posedge clk);
        if (rst_n) begin
            if (clr) begin
                modelReset();
            end else if (wr_en) begin
                m_reg[wr_addr]   = wr_data;
                m_dirty[wr_addr] = 1'b1;
                m_cnt            = m_cnt + 8'd1;
            end
        end
    endtask

    // Pull reset low between edges with a write in flight, hold across an
    // edge, then release at the following falling edge.
    task automatic midCycleReset(input string tag);
        @(negedge clk);
        #2;
        wr_en    = 1'b1;
        wr_addr  = 2'd3;
        wr_data  = 16'hAAAA;
        clr      = 1'b0;
        rd_sel_a = 2'd3;
        rd_sel_b = 2'd0;
        rst_n    = 1'b0;
        modelReset();
        #1;
        exp_q.push_back(expectNow({tag, "_async"}));
        #2;
        @(posedge clk);
        #1;
        exp_q.push_back(expectNow({tag, "_held"}));
        #2;
        @(negedge clk);
        wr_en = 1'b0;
        rst_n = 1'b1;
    endtask

    // Monitor: compares every pushed snapshot against both instances.
    initial begin
        exp_t e;
        forever begin
            wait (exp_q.size() != 0);
            #1;
            e = exp_q.pop_front();
            checkOutput({e.tag, ".rd_a"},    rd_data_a,          e.rd_a);
            checkOutput({e.tag, ".rd_b"},    rd_data_b,          e.rd_b);
            checkOutput({e.tag, ".nb_rd_a"}, nb_rd_a,            e.rd_a_nb);
            checkOutput({e.tag, ".nb_rd_b"}, nb_rd_b,            e.rd_b_nb);
            checkOutput({e.tag, ".q0"},      q0,                 e.q0);
            checkOutput({e.tag, ".q1"},      q1,                 e.q1);
            checkOutput({e.tag, ".q2"},      q2,                 e.q2);
            checkOutput({e.tag, ".q3"},      q3,                 e.q3);
            checkOutput({e.tag, ".dirty"},   {12'h000, dirty},   {12'h000, e.dirty});
            checkOutput({e.tag, ".wr_cnt"},  {8'h00, wr_cnt},    {8'h00, e.cnt});
            checkOutput({e.tag, ".nb_cnt"},  {8'h00, nb_wr_cnt}, {8'h00, e.cnt});
        end
    end

    // Watchdog so the run always reaches a summary.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=completion");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = 2'd0;
        wr_data  = 16'h0000;
        clr      = 1'b0;
        rd_sel_a = 2'd0;
        rd_sel_b = 2'd1;
        modelReset();
        #2;
        exp_q.push_back(expectNow("por"));
        #2;
        @(negedge clk);
        rst_n = 1'b1;

        // Write then read back.
        applyStimulus(1'b1, 2'd2, 16'hBEEF, 1'b0, 2'd2, 2'd0, "wr_r2");
        applyStimulus(1'b0, 2'd0, 16'h0000, 1'b0, 2'd2, 2'd2, "rd_r2");

        // Forwarding on port B; non-forwarding instance shows the old value.
        applyStimulus(1'b1, 2'd1, 16'h5555, 1'b0, 2'd0, 2'd3, "wr_r1");
        applyStimulus(1'b1, 2'd1, 16'h1234, 1'b0, 2'd2, 2'd1, "byp_r1");
        applyStimulus(1'b0, 2'd1, 16'h0000, 1'b0, 2'd1, 2'd1, "rd_r1");

        // Clear wins over a same-cycle write and suppresses forwarding.
        applyStimulus(1'b1, 2'd3, 16'h7777, 1'b0, 2'd0, 2'd1, "wr_r3");
        applyStimulus(1'b1, 2'd3, 16'hFFFF, 1'b1, 2'd3, 2'd3, "clr_wr");
        applyStimulus(1'b0, 2'd0, 16'h0000, 1'b0, 2'd3, 2'd2, "after_clr");

        // Back-to-back writes to one address: the last one wins.
        applyStimulus(1'b1, 2'd0, 16'h1111, 1'b0, 2'd1, 2'd2, "b2b_1");
        applyStimulus(1'b1, 2'd0, 16'h2222, 1'b0, 2'd0, 2'd3, "b2b_2");
        applyStimulus(1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 2'd0, "b2b_rd");

        // Counter wrap: clear, 256 writes, then an identical rewrite.
        applyStimulus(1'b0, 2'd0, 16'h0000, 1'b1, 2'd0, 2'd1, "clr_wrap");
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b1, 2'(i), 16'(i * 3 + 1), 1'b0,
                          2'(i + 1), 2'(i), $sformatf("wrap_%0d", i));
        end
        applyStimulus(1'b0, 2'd0, 16'h0000, 1'b0, 2'd3, 2'd0, "wrap_done");
        applyStimulus(1'b1, 2'd3, 16'(255 * 3 + 1), 1'b0, 2'd3, 2'd2, "rewrite");
        applyStimulus(1'b0, 2'd0, 16'h0000, 1'b0, 2'd3, 2'd1, "rewrite_rd");

        // Reset in the middle of a write stream.
        applyStimulus(1'b1, 2'd0, 16'hC0DE, 1'b0, 2'd0, 2'd1, "stream_0");
        applyStimulus(1'b1, 2'd1, 16'hFACE, 1'b0, 2'd0, 2'd1, "stream_1");
        midCycleReset("rst_mid");
        applyStimulus(1'b1, 2'd2, 16'h0BAD, 1'b0, 2'd2, 2'd3, "post_rst_wr");
        applyStimulus(1'b0, 2'd0, 16'h0000, 1'b0, 2'd2, 2'd0, "post_rst_rd");

        #20;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
